// File: rtl/lcd_spi_multi_serializer.sv
// ---------------------------------------------------------------------------
// lcd_spi_multi_serializer
//
// Serialises variable-length words onto an SPI bus shared by several LCD
// panels. Each panel has its own active-low chip select. A chip select stays
// open between words until a word marked "last" finishes. Before switching to
// a different panel, every chip select is held high for CS_GAP cycles.
//
// Parameters
//   NUM_CS   number of LCD chip selects
//   MAX_BITS widest word in bits (2..32); longer lengths are clamped
//   CLK_DIV  clk cycles per SCLK half-period (>= 1)
//   CS_GAP   clk cycles all chip selects stay high between CS changes (>= 1)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready word handshake; a word transfers when both are high
//   in_data           word, right-aligned
//   in_len            number of bits to send (0 = discard)
//   in_cs             target chip select index
//   in_dc             D/C level for the word (0 = command, 1 = data)
//   in_last           release the chip select after this word
//   lcd_busy          high while a word or a CS gap is in progress
//   lcd_sclk          SPI clock, idle low, data sampled on the rising edge
//   lcd_mosi          SPI data, MSB first
//   lcd_dc            D/C line, keeps its last value between words
//   lcd_cs_n          active-low chip selects
// ---------------------------------------------------------------------------
module lcd_spi_multi_serializer #(
  parameter  int NUM_CS   = 4,
  parameter  int MAX_BITS = 16,
  parameter  int CLK_DIV  = 1,
  parameter  int CS_GAP   = 2,
  localparam int LEN_W    = $clog2(MAX_BITS + 1),
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] in_data,
  input  logic [LEN_W-1:0]    in_len,
  input  logic [CS_W-1:0]     in_cs,
  input  logic                in_dc,
  input  logic                in_last,
  output logic                lcd_busy,
  output logic                lcd_sclk,
  output logic                lcd_mosi,
  output logic                lcd_dc,
  output logic [NUM_CS-1:0]   lcd_cs_n
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  typedef enum logic [1:0] {IDLE, GAP, LO, HI} state_t;

  state_t              state;
  logic [MAX_BITS-1:0] shreg;
  logic [LEN_W-1:0]    bits_left;
  logic [DIV_W-1:0]    div_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [CS_W-1:0]     cur_cs;
  logic [CS_W-1:0]     held_cs;
  logic                cur_dc;
  logic                cur_last;
  logic                held_valid;
  logic                gap_to_lo;

  logic [LEN_W-1:0]    len_clamped;
  logic [MAX_BITS-1:0] in_aligned;
  logic                in_cs_oob;
  logic [NUM_CS-1:0]   in_cs_sel;
  logic [NUM_CS-1:0]   cur_cs_sel;
  logic                div_done;
  logic                gap_done;

  assign in_ready = (state == IDLE) && !rst;

  // The word is left-aligned in the shift register so the current bit is
  // always the top bit. A one-hot select built by shifting naturally comes out
  // all zero for an out-of-range chip select, so such words drive no CS.
  always_comb begin
    len_clamped = (in_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : in_len;
    in_aligned  = in_data << (LEN_W'(MAX_BITS) - len_clamped);
    in_cs_oob   = (int'(in_cs) >= NUM_CS);
    in_cs_sel   = NUM_CS'(1) << in_cs;
    cur_cs_sel  = NUM_CS'(1) << cur_cs;
    div_done    = (div_cnt == DIV_W'(CLK_DIV - 1));
    gap_done    = (gap_cnt == GAP_W'(CS_GAP - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bits_left  <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      cur_cs     <= '0;
      held_cs    <= '0;
      cur_dc     <= 1'b0;
      cur_last   <= 1'b0;
      held_valid <= 1'b0;
      gap_to_lo  <= 1'b0;
      lcd_busy   <= 1'b0;
      lcd_sclk   <= 1'b0;
      lcd_mosi   <= 1'b0;
      lcd_dc     <= 1'b0;
      lcd_cs_n   <= '1;
    end else begin
      case (state)
        IDLE: begin
          // Zero-length words are consumed by the handshake and leave
          // everything, including an open chip select, untouched.
          if (in_valid && (len_clamped != '0)) begin
            shreg     <= in_aligned;
            bits_left <= len_clamped;
            cur_cs    <= in_cs;
            cur_dc    <= in_dc;
            cur_last  <= in_last || in_cs_oob;
            lcd_busy  <= 1'b1;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            if (held_valid && (held_cs != in_cs)) begin
              state      <= GAP;
              lcd_cs_n   <= '1;
              held_valid <= 1'b0;
              gap_to_lo  <= 1'b1;
            end else begin
              state    <= LO;
              lcd_cs_n <= ~in_cs_sel;
              lcd_dc   <= in_dc;
              lcd_mosi <= in_aligned[MAX_BITS-1];
            end
          end
        end

        // A gap either separates two panels (then the pending word starts)
        // or closes a transaction (then the block goes idle).
        GAP: begin
          if (gap_done) begin
            gap_cnt <= '0;
            if (gap_to_lo) begin
              state     <= LO;
              gap_to_lo <= 1'b0;
              div_cnt   <= '0;
              lcd_cs_n  <= ~cur_cs_sel;
              lcd_dc    <= cur_dc;
              lcd_mosi  <= shreg[MAX_BITS-1];
            end else begin
              state    <= IDLE;
              lcd_busy <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        LO: begin
          if (div_done) begin
            state    <= HI;
            div_cnt  <= '0;
            lcd_sclk <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HI: begin
          if (div_done) begin
            div_cnt  <= '0;
            lcd_sclk <= 1'b0;
            if (bits_left > LEN_W'(1)) begin
              state     <= LO;
              bits_left <= bits_left - LEN_W'(1);
              shreg     <= shreg << 1;
              lcd_mosi  <= shreg[MAX_BITS-2];
            end else begin
              lcd_mosi <= 1'b0;
              if (cur_last) begin
                state      <= GAP;
                gap_cnt    <= '0;
                gap_to_lo  <= 1'b0;
                held_valid <= 1'b0;
                lcd_cs_n   <= '1;
              end else begin
                state      <= IDLE;
                lcd_busy   <= 1'b0;
                held_valid <= 1'b1;
                held_cs    <= cur_cs;
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_multi_serializer.sv
// ---------------------------------------------------------------------------
// tb_lcd_spi_multi_serializer
//
// Directed bench for lcd_spi_multi_serializer. One instance uses the default
// parameters (CLK_DIV=1); a second instance uses CLK_DIV=3 for the divided
// clock and length-clamp case. Inputs change and outputs are sampled 1 time
// unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_lcd_spi_multi_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_valid3 = 1'b0;
  logic [15:0] in_data = '0;
  logic [4:0]  in_len = '0;
  logic [1:0]  in_cs = '0;
  logic        in_dc = 1'b0;
  logic        in_last = 1'b0;

  logic        in_ready, lcd_busy, lcd_sclk, lcd_mosi, lcd_dc;
  logic [3:0]  lcd_cs_n;
  logic        in_ready3, lcd_busy3, lcd_sclk3, lcd_mosi3, lcd_dc3;
  logic [3:0]  lcd_cs_n3;

  int n_checks = 0;
  int n_fail   = 0;
  int rises    = 0;
  int rises0;

  always #5 clk = ~clk;

  always @(posedge lcd_sclk) rises++;

  lcd_spi_multi_serializer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .in_cs(in_cs),
    .in_dc(in_dc), .in_last(in_last),
    .lcd_busy(lcd_busy), .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi),
    .lcd_dc(lcd_dc), .lcd_cs_n(lcd_cs_n)
  );

  lcd_spi_multi_serializer #(.NUM_CS(4), .MAX_BITS(16), .CLK_DIV(3), .CS_GAP(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data), .in_len(in_len), .in_cs(in_cs),
    .in_dc(in_dc), .in_last(in_last),
    .lcd_busy(lcd_busy3), .lcd_sclk(lcd_sclk3), .lcd_mosi(lcd_mosi3),
    .lcd_dc(lcd_dc3), .lcd_cs_n(lcd_cs_n3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_output_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_output_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Offer one word to the CLK_DIV=1 instance for a single accepting cycle.
  task automatic apply_stimulus(input logic [15:0] data, input logic [4:0] len,
                                input logic [1:0] cs, input logic dc, input logic last);
    check_output("ready_before_accept", in_ready, 1'b1);
    in_data  = data;
    in_len   = len;
    in_cs    = cs;
    in_dc    = dc;
    in_last  = last;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Walk through the 2*len LO/HI cycles of a word at CLK_DIV=1.
  task automatic run_word(input logic [15:0] word, input int len,
                          input logic [3:0] csn_exp, input logic dc_exp);
    logic [15:0] tmp;
    for (int k = 0; k < 2 * len; k++) begin
      tmp = word >> (len - 1 - k / 2);
      check_output_vec("word_cs_n", lcd_cs_n, csn_exp);
      check_output("word_sclk", lcd_sclk, (k % 2) == 1);
      check_output("word_mosi", lcd_mosi, tmp[0]);
      check_output("word_dc", lcd_dc, dc_exp);
      check_output("word_busy", lcd_busy, 1'b1);
      step();
    end
  endtask

  // Closing gap after a last word: all CS high for two cycles, then idle.
  task automatic expect_gap_then_idle();
    check_output_vec("gap1_cs_n", lcd_cs_n, 4'b1111);
    check_output("gap1_sclk", lcd_sclk, 1'b0);
    check_output("gap1_mosi", lcd_mosi, 1'b0);
    check_output("gap1_busy", lcd_busy, 1'b1);
    check_output("gap1_ready", in_ready, 1'b0);
    step();
    check_output_vec("gap2_cs_n", lcd_cs_n, 4'b1111);
    check_output("gap2_busy", lcd_busy, 1'b1);
    step();
    check_output("idle_ready", in_ready, 1'b1);
    check_output("idle_busy", lcd_busy, 1'b0);
    check_output_vec("idle_cs_n", lcd_cs_n, 4'b1111);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] tmp;

    // Reset values
    step();
    step();
    check_output("rst_ready", in_ready, 1'b0);
    check_output("rst_busy", lcd_busy, 1'b0);
    check_output_vec("rst_cs_n", lcd_cs_n, 4'b1111);
    check_output("rst_sclk", lcd_sclk, 1'b0);
    check_output("rst_mosi", lcd_mosi, 1'b0);
    check_output("rst_dc", lcd_dc, 1'b0);
    rst = 1'b0;
    #1;
    check_output("post_rst_ready", in_ready, 1'b1);
    check_output("post_rst_ready3", in_ready3, 1'b1);

    // 0xA5, 8 bits, cs 2, last
    $display("[TB] single word 0xA5 to cs 2");
    apply_stimulus(16'h00A5, 5'd8, 2'd2, 1'b1, 1'b1);
    check_output("a5_ready_busy", in_ready, 1'b0);
    run_word(16'h00A5, 8, 4'b1011, 1'b1);
    expect_gap_then_idle();

    // Two words to cs 1 without releasing the chip select
    $display("[TB] two words to cs 1");
    rises0 = rises;
    apply_stimulus(16'h1234, 5'd16, 2'd1, 1'b0, 1'b0);
    run_word(16'h1234, 16, 4'b1101, 1'b0);
    check_output("hold_ready", in_ready, 1'b1);
    check_output("hold_busy", lcd_busy, 1'b0);
    check_output_vec("hold_cs_n", lcd_cs_n, 4'b1101);
    check_output("hold_sclk", lcd_sclk, 1'b0);
    check_output("hold_mosi", lcd_mosi, 1'b0);
    check_output("hold_dc", lcd_dc, 1'b0);
    apply_stimulus(16'h000F, 5'd8, 2'd1, 1'b1, 1'b1);
    run_word(16'h000F, 8, 4'b1101, 1'b1);
    expect_gap_then_idle();
    check_output_int("sclk_pulses_24", rises - rises0, 24);

    // Switch from cs 0 to cs 3 through a CS gap
    $display("[TB] chip select switch 0 -> 3");
    apply_stimulus(16'h0003, 5'd2, 2'd0, 1'b0, 1'b0);
    run_word(16'h0003, 2, 4'b1110, 1'b0);
    check_output_vec("sw_hold_cs_n", lcd_cs_n, 4'b1110);
    apply_stimulus(16'h0001, 5'd1, 2'd3, 1'b1, 1'b1);
    check_output_vec("sw_gap1_cs_n", lcd_cs_n, 4'b1111);
    check_output("sw_gap1_busy", lcd_busy, 1'b1);
    check_output("sw_gap1_ready", in_ready, 1'b0);
    check_output("sw_gap1_dc", lcd_dc, 1'b0);
    check_output("sw_gap1_sclk", lcd_sclk, 1'b0);
    step();
    check_output_vec("sw_gap2_cs_n", lcd_cs_n, 4'b1111);
    check_output("sw_gap2_mosi", lcd_mosi, 1'b0);
    step();
    run_word(16'h0001, 1, 4'b0111, 1'b1);
    expect_gap_then_idle();

    // Zero-length word while cs 2 is held open
    $display("[TB] zero-length word");
    apply_stimulus(16'h0002, 5'd2, 2'd2, 1'b0, 1'b0);
    run_word(16'h0002, 2, 4'b1011, 1'b0);
    rises0 = rises;
    apply_stimulus(16'hFFFF, 5'd0, 2'd0, 1'b1, 1'b1);
    check_output("len0_ready", in_ready, 1'b1);
    check_output("len0_busy", lcd_busy, 1'b0);
    check_output_vec("len0_cs_n", lcd_cs_n, 4'b1011);
    check_output("len0_dc", lcd_dc, 1'b0);
    step();
    check_output("len0_busy2", lcd_busy, 1'b0);
    check_output_int("len0_no_sclk", rises - rises0, 0);
    apply_stimulus(16'h0001, 5'd1, 2'd2, 1'b1, 1'b1);
    run_word(16'h0001, 1, 4'b1011, 1'b1);
    expect_gap_then_idle();

    // CLK_DIV=3 instance, length 20 clamped to 16 bits
    $display("[TB] divided clock with clamped length");
    check_output("div3_ready", in_ready3, 1'b1);
    in_data   = 16'h8001;
    in_len    = 5'd20;
    in_cs     = 2'd0;
    in_dc     = 1'b1;
    in_last   = 1'b0;
    in_valid3 = 1'b1;
    step();
    in_valid3 = 1'b0;
    for (int k = 0; k < 96; k++) begin
      tmp = 16'h8001 >> (15 - k / 6);
      check_output_vec("div3_cs_n", lcd_cs_n3, 4'b1110);
      check_output("div3_sclk", lcd_sclk3, ((k / 3) % 2) == 1);
      check_output("div3_mosi", lcd_mosi3, tmp[0]);
      check_output("div3_busy", lcd_busy3, 1'b1);
      step();
    end
    check_output("div3_end_busy", lcd_busy3, 1'b0);
    check_output("div3_end_ready", in_ready3, 1'b1);
    check_output("div3_end_sclk", lcd_sclk3, 1'b0);
    check_output_vec("div3_end_cs_n", lcd_cs_n3, 4'b1110);
    check_output("div3_end_dc", lcd_dc3, 1'b1);

    // Reset in the middle of a word
    $display("[TB] reset mid-word");
    apply_stimulus(16'hFFFF, 5'd16, 2'd1, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step();
    check_output_vec("pre_rst_cs_n", lcd_cs_n, 4'b1101);
    rst = 1'b1;
    step();
    check_output_vec("mid_rst_cs_n", lcd_cs_n, 4'b1111);
    check_output("mid_rst_sclk", lcd_sclk, 1'b0);
    check_output("mid_rst_mosi", lcd_mosi, 1'b0);
    check_output("mid_rst_dc", lcd_dc, 1'b0);
    check_output("mid_rst_busy", lcd_busy, 1'b0);
    check_output("mid_rst_ready", in_ready, 1'b0);
    check_output_vec("mid_rst_cs_n3", lcd_cs_n3, 4'b1111);
    rst = 1'b0;
    #1;
    check_output("after_rst_ready", in_ready, 1'b1);
    apply_stimulus(16'h8000, 5'd16, 2'd1, 1'b1, 1'b1);
    run_word(16'h8000, 16, 4'b1101, 1'b1);
    expect_gap_then_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
